ram_arb_2p: RTL

RAM_ARB_2P -- requirements
Module: ram_arb_2p

---
 rtl/ram_arb_2p.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ram_arb_2p.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_2p
// Purpose  : Two-port arbiter in front of a single-port synchronous RAM.
//            One access at a time runs through a three-state sequence:
//            IDLE (pick winner, latch its command) -> ISSUE (drive the RAM
//            for one cycle, pulse gnt) -> [WAIT (capture read data)] -> IDLE.
//            A write takes 2 cycles, a read 3 cycles, back to back.
// Config   : `define RAM_ARB_RR_EN  -> round-robin arbitration on contention
//            (last-winner pointer, reset favours port 0).
//            Undefined (default)   -> fixed priority, port 0 always wins.
// Ports    : clk, rst            clock, synchronous active-high reset
//            req0/1, rw0/1       request and direction (1 = write) per port
//            addr0/1, wdata0/1   command address / write data per port
//            gnt0/1              one-cycle pulse when the command is issued
//            rdata0/1, rvalid0/1 read data and its one-cycle valid pulse
//            ram_en/rw/addr/din  RAM command (ram_en high one cycle/access)
//            ram_dout            registered RAM read data (1-cycle latency)
// Revision : 1.0  initial release
// ============================================================================
module ram_arb_2p #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          ram_en,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_take;      // accept a request this cycle
    logic          w_win_nxt;   // 0 = port 0, 1 = port 1
    logic          w_issue;

    logic          r_win;       // owner of the access in flight
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_rvalid0;
    logic          r_rvalid1;

`ifdef RAM_ARB_RR_EN
    logic          r_last;      // port granted most recently

    // Contention goes to the port not granted last; a lone requester
    // always wins regardless of the pointer.
    always_comb begin
        w_win_nxt = req1;
        if (req0 && req1) begin
            w_win_nxt = ~r_last;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not requesting.
    always_comb begin
        w_win_nxt = ~req0;
    end
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req0 || req1) begin
                    w_take      = 1'b1;
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_state_nxt = r_rw ? c_IDLE : c_WAIT;
            end
            c_WAIT: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_win     <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
`ifdef RAM_ARB_RR_EN
            // Pretend port 1 won last so port 0 is favoured after reset.
            r_last    <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;

            if (w_take) begin
                r_win   <= w_win_nxt;
                r_rw    <= w_win_nxt ? rw1    : rw0;
                r_addr  <= w_win_nxt ? addr1  : addr0;
                r_wdata <= w_win_nxt ? wdata1 : wdata0;
            end

            // ram_dout is valid during WAIT; rvalid lands in the IDLE after.
            r_rvalid0 <= (r_state == c_WAIT) && !r_win;
            r_rvalid1 <= (r_state == c_WAIT) &&  r_win;
            if (r_state == c_WAIT) begin
                if (r_win) begin
                    r_rdata1 <= ram_dout;
                end else begin
                    r_rdata0 <= ram_dout;
                end
            end

`ifdef RAM_ARB_RR_EN
            if (r_state == c_ISSUE) begin
                r_last <= r_win;
            end
`endif
        end
    end

    // RAM command and grants are decoded straight from registered state,
    // so they are glitch-free and only active during ISSUE.
    assign w_issue  = (r_state == c_ISSUE);
    assign gnt0     = w_issue && !r_win;
    assign gnt1     = w_issue &&  r_win;
    assign ram_en   = w_issue;
    assign ram_rw   = w_issue && r_rw;
    assign ram_addr = r_addr;
    assign ram_din  = r_wdata;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;

endmodule
`default_nettype wire
